// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - sequential instruction prefetch with DEPTH-entry {pc, inst} queue and redirect squash
module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      br_ctrl,
    input  logic [ADDR_W-1:0]         br_addr,
    input  logic                      pc_stall,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [INST_W-1:0]         imem_rdata,
    output logic                      if_valid,
    output logic [INST_W-1:0]         if_inst,
    output logic [ADDR_W-1:0]         if_pc,
    output logic [$clog2(DEPTH):0]    fifo_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic              issue;
    logic              push;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;

    // Credit counts the outstanding request so its response always has a slot.
    assign occupancy = {1'b0, count} + OCC_W'(inflight);
    assign issue     = rst & ~br_ctrl & (occupancy < OCC_W'(DEPTH));
    assign push      = inflight & ~br_ctrl;
    assign pop       = if_valid & ~pc_stall & ~br_ctrl;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign if_valid  = (count != '0);
    assign if_pc     = pc_mem[rd_ptr];
    assign if_inst   = inst_mem[rd_ptr];
    assign fifo_cnt  = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (br_ctrl) begin
            fetch_pc <= br_addr & ~ADDR_W'(3);
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
                inflight_pc <= fetch_pc;
            end
            inflight <= issue;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only count decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed self-checking bench for if_prefetch
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_ctrl;
    logic [31:0] br_addr;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0BAD_0BAD;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [2:0]  fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    if_prefetch #(
        .ADDR_W  (32),
        .INST_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0),
        .PC_STEP (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .br_ctrl   (br_ctrl),
        .br_addr   (br_addr),
        .pc_stall  (pc_stall),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // One-cycle-latency instruction memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= inst_of(imem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        br_ctrl  = 1'b0;
        br_addr  = 32'h0;
        pc_stall = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_req",   imem_req,  1'b0);
        chk("rst_valid", if_valid,  1'b0);
        chk("rst_cnt",   fifo_cnt,  3'd0);
        chk("rst_addr",  imem_addr, 32'h0);

        // Reset release, free-running fetch
        rst = 1'b1;
        #1;
        chk("c0_req",  imem_req,  1'b1);
        chk("c0_addr", imem_addr, 32'h0);
        tick();
        chk("c1_addr",  imem_addr, 32'h4);
        chk("c1_valid", if_valid,  1'b0);
        tick();
        chk("c2_valid", if_valid,  1'b1);
        chk("c2_pc",    if_pc,     32'h0);
        chk("c2_inst",  if_inst,   inst_of(32'h0));
        chk("c2_addr",  imem_addr, 32'h8);
        chk("c2_cnt",   fifo_cnt,  3'd1);
        tick();
        chk("c3_pc",   if_pc,   32'h4);
        chk("c3_inst", if_inst, inst_of(32'h4));
        tick();
        chk("c4_pc",  if_pc,    32'h8);
        chk("c4_cnt", fifo_cnt, 3'd1);

        // Stall from cycle 2 fills the queue, release drains in order
        restart();
        tick();
        tick();
        pc_stall = 1'b1;
        tick();
        tick();
        chk("st_c4_cnt", fifo_cnt, 3'd3);
        chk("st_c4_req", imem_req, 1'b0);
        tick();
        chk("st_full_cnt",  fifo_cnt,  3'd4);
        chk("st_full_req",  imem_req,  1'b0);
        chk("st_full_pc",   if_pc,     32'h0);
        chk("st_full_addr", imem_addr, 32'h10);
        tick();
        chk("st_hold_cnt", fifo_cnt, 3'd4);
        pc_stall = 1'b0;
        #1;
        chk("st_rel_req", imem_req, 1'b0);
        tick();
        chk("st_p1_pc",   if_pc,     32'h4);
        chk("st_p1_cnt",  fifo_cnt,  3'd3);
        chk("st_p1_req",  imem_req,  1'b1);
        chk("st_p1_addr", imem_addr, 32'h10);
        tick();
        chk("st_p2_pc",  if_pc,    32'h8);
        chk("st_p2_cnt", fifo_cnt, 3'd2);
        tick();
        chk("st_p3_pc", if_pc, 32'hC);
        tick();
        chk("st_p4_pc",   if_pc,   32'h10);
        chk("st_p4_inst", if_inst, inst_of(32'h10));

        // Redirect with 3 queued entries and one in flight
        restart();
        tick();
        tick();
        pc_stall = 1'b1;
        tick();
        tick();
        chk("br_pre_cnt", fifo_cnt, 3'd3);
        br_ctrl = 1'b1;
        br_addr = 32'h100;
        #1;
        chk("br_req_off", imem_req, 1'b0);
        tick();
        chk("br_t1_valid", if_valid, 1'b0);
        chk("br_t1_cnt",   fifo_cnt, 3'd0);
        br_ctrl  = 1'b0;
        pc_stall = 1'b0;
        #1;
        chk("br_t1_req",  imem_req,  1'b1);
        chk("br_t1_addr", imem_addr, 32'h100);
        tick();
        chk("br_t2_valid", if_valid, 1'b0);
        tick();
        chk("br_t3_valid", if_valid, 1'b1);
        chk("br_t3_pc",    if_pc,    32'h100);
        chk("br_t3_inst",  if_inst,  inst_of(32'h100));

        // Redirect held 3 cycles to a misaligned target
        br_ctrl = 1'b1;
        br_addr = 32'h203;
        #1;
        chk("bh0_req", imem_req, 1'b0);
        tick();
        chk("bh1_req",   imem_req, 1'b0);
        chk("bh1_valid", if_valid, 1'b0);
        tick();
        chk("bh2_req", imem_req, 1'b0);
        tick();
        chk("bh3_req", imem_req, 1'b0);
        br_ctrl = 1'b0;
        #1;
        chk("bh_req",  imem_req,  1'b1);
        chk("bh_addr", imem_addr, 32'h200);
        tick();
        tick();
        chk("bh_pc", if_pc, 32'h200);

        // Address wrap-around
        br_ctrl = 1'b1;
        br_addr = 32'hFFFF_FFF8;
        tick();
        br_ctrl = 1'b0;
        #1;
        chk("wr_a0", imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("wr_a1", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_a2",   imem_addr, 32'h0);
        chk("wr_req2", imem_req,  1'b1);
        chk("wr_pc0",  if_pc,     32'hFFFF_FFF8);
        tick();
        tick();
        chk("wr_pc2",   if_pc,   32'h0);
        chk("wr_inst2", if_inst, inst_of(32'h0));

        // Asynchronous reset with a full queue
        pc_stall = 1'b1;
        repeat (6) tick();
        chk("ar_full_cnt",   fifo_cnt, 3'd4);
        chk("ar_full_req",   imem_req, 1'b0);
        chk("ar_full_valid", if_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", if_valid,  1'b0);
        chk("ar_cnt",   fifo_cnt,  3'd0);
        chk("ar_req",   imem_req,  1'b0);
        chk("ar_addr",  imem_addr, 32'h0);
        @(negedge clk);
        rst      = 1'b1;
        pc_stall = 1'b0;
        #1;
        chk("ar_c0_req",  imem_req,  1'b1);
        chk("ar_c0_addr", imem_addr, 32'h0);
        tick();
        chk("ar_c1_addr", imem_addr, 32'h4);
        tick();
        chk("ar_c2_valid", if_valid, 1'b1);
        chk("ar_c2_pc",    if_pc,    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch stage with a prefetch queue. It supersedes the single-register PC fetch path. It issues sequential requests to a fixed one-cycle-latency instruction memory and buffers returned {pc, inst} pairs in a DEPTH-entry FIFO. The pair is presented to decode with a valid/ready handshake, and all buffered and in-flight fetches are squashed on a branch redirect. It sits between the branch-resolution logic and the decode stage.

## Interface
- ADDR_W, 32: PC/address width.
- INST_W, 32: instruction width.
- DEPTH, 4: FIFO entries; power of two, >= 4.
- RESET_PC, 0: first fetch address after reset.
- PC_STEP, 4: sequential PC increment.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- br_ctrl  in  1  redirect request; fetch restarts at br_addr.
- br_addr  in  ADDR_W  redirect target; bits [1:0] forced to 0 internally.
- pc_stall  in  1  decode not ready; pop suppressed while 1.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  fetch address; valid when imem_req=1.
- imem_rdata  in  INST_W  instruction for the request issued the previous cycle.
- if_valid  out  1  head entry valid.
- if_inst  out  INST_W  head instruction.
- if_pc  out  ADDR_W  head PC.
- fifo_cnt  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: fetch_pc, inflight flag (one request outstanding), inflight_pc, FIFO storage plus rd/wr pointers and count.
- Issue rule: imem_req = rst & ~br_ctrl & (count + inflight < DEPTH). imem_addr = fetch_pc. A same-cycle pop grants no credit.
- On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP. Wrap-around is modulo 2^ADDR_W.
- Response: if inflight=1 and there was no redirect this cycle, push {inflight_pc, imem_rdata}. Then inflight <= 1 only if a new request is issued.
- Pop: occurs when if_valid & ~pc_stall. rd pointer advances.
- Pointers wrap modulo DEPTH. Occupancy comes from count, not a pointer compare. The credit rule makes overflow impossible.
- Redirect (br_ctrl=1): count, pointers and inflight are cleared, and fetch_pc <= {br_addr[ADDR_W-1:2], 2'b00}. The pending response is discarded, and so is any same-cycle pop or push. No request is issued that cycle.
- br_ctrl held N cycles: fetch_pc is reloaded each cycle, and no requests are issued until it drops.
- if_valid = (count != 0). if_inst/if_pc are driven combinationally from the head entry. When the FIFO is empty they hold the last head contents (don't-care).

## Timing
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, inflight=0, count=0, pointers=0, if_valid=0, fifo_cnt=0, imem_req=0. imem_addr shows RESET_PC.
- Cycle 0 = first edge with rst=1. In cycle 0, imem_req=1 with addr=RESET_PC. Data arrives in cycle 1 and is pushed at the end of cycle 1. if_valid=1 in cycle 2.
- Fetch-to-output latency is 2 cycles. Redirect at cycle t: request for br_addr in t+1, if_valid for br_addr in t+3.
- Steady state with pc_stall=0: one instruction per cycle (count=1, inflight=1).
- With pc_stall=1 held: the FIFO fills to DEPTH, then imem_req=0. When the stall is released, the next request follows one cycle after the first pop.
- Simultaneous push and pop: count is unchanged.
- Reset asserted mid-operation: all state clears immediately. Outputs take their reset values without waiting for a clock.

## Test plan
- Reset release, RESET_PC=0, pc_stall=0: imem_addr is 0,4,8,... on consecutive cycles. if_valid rises in cycle 2, and if_pc runs 0,4,8 back-to-back with matching if_inst.
- pc_stall=1 from cycle 2, DEPTH=4: fifo_cnt reaches 4 and imem_req=0 with no lost or duplicated PCs. After release, pops return 0,4,8,12,16 in order.
- br_ctrl=1 for one cycle with br_addr=0x100 while the FIFO holds 3 entries and a request is in flight: if_valid=0 the next cycle and fifo_cnt=0. imem_addr=0x100 one cycle later, and if_pc=0x100 at t+3 with no stale entry.
- br_addr=0x203 with br_ctrl asserted for 3 cycles: no requests while asserted. The first fetch is 0x200.
- fetch_pc=0xFFFF_FFFC followed by sequential fetch: the next request is 0x0000_0000.
- rst dropped asynchronously between edges with a full FIFO: if_valid, fifo_cnt and imem_req go to 0 at once. Restart follows the reset-release scenario.
